split_mem_sync: RTL
===================

SPLIT_MEM_SYNC -- requirements
Module: split_mem_sync

Interface
REQ-001 SHALL have parameter ADDR_W, default 14: word-address width of each memory (2^ADDR_W words).
REQ-002 SHALL have parameter DATA_W, default 32: word width, a multiple of 8.
REQ-003 SHALL have parameter LOG_W, default 8: dirty-log depth DEPTH = 2^LOG_W entries.
REQ-004 SHALL have parameter WRITE_THROUGH, default 0: 1 selects write-through mode, 0 selects dirty-log mode.
REQ-005 i_clk  in  1  clock; all logic on posedge.
REQ-006 i_rst  in  1  reset, synchronous, active-high.
REQ-007 i_im_ren, i_im_addr  in  1, ADDR_W  instruction read request and word address.
REQ-008 o_im_rdata  out  DATA_W  instruction read data.
REQ-009 i_dm_ren, i_dm_wen  in  1, 1  data read and write requests.
REQ-010 i_dm_ben, i_dm_addr, i_dm_wdata  in  DATA_W/8, ADDR_W, DATA_W  byte enables, address and write data.
REQ-011 o_dm_rdata  out  DATA_W  data read data.
REQ-012 i_fence_i  in  1  request to make IM coherent with DM.
REQ-013 o_ready  out  1  high when DM writes and fences are accepted.
REQ-014 o_overrun  out  1  sticky flag: a write or fence arrived while o_ready was low.

Function
REQ-015 SHALL hold internal IM and DM arrays of 2^ADDR_W x DATA_W; IM has one read port and one write port, DM has one shared port.
REQ-016 IM read: o_im_rdata SHALL equal IM[i_im_addr] one cycle after i_im_ren is sampled high, and SHALL hold its value otherwise.
REQ-017 DM read: o_dm_rdata SHALL equal DM[i_dm_addr] one cycle after i_dm_ren is sampled high while o_ready is high, and SHALL hold its value otherwise.
REQ-018 DM write: when i_dm_wen and o_ready are high, DM SHALL update only the bytes whose i_dm_ben bit is 1; a simultaneous read of the same address SHALL return the old data.
REQ-019 Log mode: each accepted DM write SHALL append i_dm_addr to the log at index count; count increments by 1. Duplicate addresses are logged again.
REQ-020 The FSM SHALL have states IDLE, COPY and DRAIN, with o_ready = (state==IDLE) && (count<DEPTH).
REQ-021 IDLE->COPY SHALL occur when i_fence_i is accepted with count>0, or when count reaches DEPTH.
REQ-022 IDLE->DRAIN SHALL occur when i_fence_i is accepted with count==0.
REQ-023 COPY, index k=0..count-1, one per cycle: read DM[log[k]]; in the following cycle write that word to IM[log[k]] with all bytes enabled.
REQ-024 COPY->DRAIN SHALL occur after the read of the last entry; DRAIN performs the final IM write, clears count to 0, and returns to IDLE.
REQ-025 A sync of N entries SHALL hold o_ready low for exactly N+1 cycles; an empty fence holds it low for exactly 1 cycle.
REQ-026 Write and fence in the same IDLE cycle: the write SHALL be performed and logged first, and the sync SHALL include it.
REQ-027 The write that brings count to DEPTH SHALL be accepted; o_ready SHALL drop the next cycle and a sync of DEPTH entries SHALL start automatically.
REQ-028 Writes, reads or fences while o_ready is low SHALL be ignored; a write or fence in that state SHALL set o_overrun.
REQ-029 During COPY and DRAIN, fetch reads SHALL continue; an IM read of an address written in the same cycle SHALL return the old data.
REQ-030 Write-through mode: each accepted DM write SHALL write IM in the same cycle with the same byte enables; the log SHALL be unused.
REQ-031 Write-through mode: a fence SHALL hold o_ready low for exactly 1 cycle (DRAIN only).

Reset
REQ-032 On i_rst: state=IDLE, count=0, o_overrun=0, o_im_rdata=0, o_dm_rdata=0; o_ready=1 in the following cycle.
REQ-033 Reset mid-sync SHALL abort the copy; IM keeps any words already copied; memory contents SHALL not be cleared.

Verification
REQ-034 Write DM[5]=0xDEADBEEF (ben=1111), pulse fence; then IM read addr 5 -> o_ready low 2 cycles, o_im_rdata=0xDEADBEEF.
REQ-035 Writes to addresses 1,2,2,3, then fence -> o_ready low 5 cycles; IM[1..3] equal DM[1..3].
REQ-036 LOG_W=2: four writes -> auto sync, o_ready low 5 cycles; a 5th write during sync is dropped and o_overrun=1.
REQ-037 Write with ben=0010 to a word holding 0x11223344, data 0xAABBCCDD -> DM word becomes 0x1122CC44 and, after fence, IM matches.
REQ-038 Assert i_rst during COPY of 4 entries -> next cycle o_ready=1, count=0; a fence then gives a 1-cycle low.
REQ-039 WRITE_THROUGH=1: write DM[7]=0x12345678 -> IM[7]=0x12345678 with no fence; a fence gives o_ready low exactly 1 cycle.

Source files
------------

// File: rtl/split_mem_sync.sv
// Split instruction/data memories with a fence.i sync engine. DM writes are either
// logged and replayed into IM on a fence, or mirrored into IM immediately (write-through).
module split_mem_sync #(
  parameter int          ADDR_W        = 14,
  parameter int          DATA_W        = 32,
  parameter int          LOG_W         = 8,
  parameter int unsigned WRITE_THROUGH = 0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_im_ren,
  input  logic [ADDR_W-1:0]   i_im_addr,
  output logic [DATA_W-1:0]   o_im_rdata,
  input  logic                i_dm_ren,
  input  logic                i_dm_wen,
  input  logic [DATA_W/8-1:0] i_dm_ben,
  input  logic [ADDR_W-1:0]   i_dm_addr,
  input  logic [DATA_W-1:0]   i_dm_wdata,
  output logic [DATA_W-1:0]   o_dm_rdata,
  input  logic                i_fence_i,
  output logic                o_ready,
  output logic                o_overrun
);
  localparam int   NB    = DATA_W / 8;
  localparam int   DEPTH = 1 << LOG_W;
  localparam int   CNT_W = LOG_W + 1;
  localparam logic WT    = (WRITE_THROUGH != 0);

  typedef enum logic [1:0] {S_IDLE, S_COPY, S_DRAIN} state_e;

  logic [DATA_W-1:0] im_mem  [2**ADDR_W];
  logic [DATA_W-1:0] dm_mem  [2**ADDR_W];
  logic [ADDR_W-1:0] log_mem [DEPTH];

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d, count_inc;
  logic [LOG_W-1:0]  idx_q, idx_d;
  logic              overrun_q, overrun_d;
  logic              cp_wen_q, cp_wen_d;
  logic [ADDR_W-1:0] cp_addr_q, cp_addr_d;
  logic [DATA_W-1:0] cp_rdata_q, im_rdata_q, dm_rdata_q;

  logic              ready, wr_acc, rd_acc, fence_acc, log_we, copy_rd;
  logic [ADDR_W-1:0] log_addr;
  logic              im_we;
  logic [NB-1:0]     im_ben;
  logic [ADDR_W-1:0] im_waddr;
  logic [DATA_W-1:0] im_wdata;

  always_comb begin
    ready     = (state_q == S_IDLE) && (count_q < CNT_W'(DEPTH));
    wr_acc    = i_dm_wen && ready;
    rd_acc    = i_dm_ren && ready;
    fence_acc = i_fence_i && ready;
    log_we    = wr_acc && !WT;
    count_inc = count_q + CNT_W'(log_we);
    log_addr  = log_mem[idx_q];
    copy_rd   = (state_q == S_COPY);

    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    cp_wen_d  = 1'b0;
    cp_addr_d = cp_addr_q;
    overrun_d = overrun_q | ((i_dm_wen | i_fence_i) & ~ready);

    case (state_q)
      S_IDLE: begin
        // A write in the fence cycle is logged first so the sync covers it
        count_d = count_inc;
        idx_d   = '0;
        if (fence_acc)                           state_d = (count_inc != '0) ? S_COPY : S_DRAIN;
        else if (count_inc == CNT_W'(DEPTH))     state_d = S_COPY;
      end
      S_COPY: begin
        cp_wen_d  = 1'b1;
        cp_addr_d = log_addr;
        idx_d     = idx_q + LOG_W'(1);
        if ({1'b0, idx_q} == count_q - CNT_W'(1)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        count_d = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (WT) begin
      im_we    = wr_acc;
      im_ben   = i_dm_ben;
      im_waddr = i_dm_addr;
      im_wdata = i_dm_wdata;
    end else begin
      im_we    = cp_wen_q;
      im_ben   = '1;
      im_waddr = cp_addr_q;
      im_wdata = cp_rdata_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      cp_wen_q  <= 1'b0;
      cp_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      cp_wen_q  <= cp_wen_d;
      cp_addr_q <= cp_addr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (log_we) log_mem[count_q[LOG_W-1:0]] <= i_dm_addr;
  end

  // DM single port: user access in IDLE, copy-engine reads in COPY
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < NB; b++)
      if (wr_acc && i_dm_ben[b]) dm_mem[i_dm_addr][b*8 +: 8] <= i_dm_wdata[b*8 +: 8];
    if (copy_rd) cp_rdata_q <= dm_mem[log_addr];
    if (i_rst)       dm_rdata_q <= '0;
    else if (rd_acc) dm_rdata_q <= dm_mem[i_dm_addr];
  end

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < NB; b++)
      if (im_we && im_ben[b]) im_mem[im_waddr][b*8 +: 8] <= im_wdata[b*8 +: 8];
    if (i_rst)         im_rdata_q <= '0;
    else if (i_im_ren) im_rdata_q <= im_mem[i_im_addr];
  end

  assign o_im_rdata = im_rdata_q;
  assign o_dm_rdata = dm_rdata_q;
  assign o_ready    = ready;
  assign o_overrun  = overrun_q;
endmodule
